// File: rtl/act_row_drain_buffer.sv
// Row FIFO between the activation unit and the output cache/DMA.
// It captures whole Q8.8 rows on a strobe and streams them out one element per valid/ready beat.
module act_row_drain_buffer #(
  parameter int DATA_WIDTH  = 16,
  parameter int MATRIX_SIZE = 8,
  parameter int ROW_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] in_data,
  input  logic                              in_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic [$clog2(ROW_DEPTH+1)-1:0]    row_count,
  output logic                              full,
  output logic                              overflow
);

  localparam int CW = $clog2(ROW_DEPTH + 1);
  localparam int PW = $clog2(ROW_DEPTH);
  localparam int EW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(ROW_DEPTH);
  localparam logic [EW-1:0] LAST_IDX = EW'(MATRIX_SIZE - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   wr_ptr, wr_ptr_d;
  logic [PW-1:0]   rd_ptr, rd_ptr_d;
  logic [EW-1:0]   elem_idx, elem_idx_d;
  logic [CW-1:0]   row_count_d;
  logic            overflow_d;
  logic            beat, pop, push;

  logic [DATA_WIDTH-1:0] mem [ROW_DEPTH][MATRIX_SIZE];

  assign out_valid = (state == SEND);
  assign out_last  = out_valid && (elem_idx == LAST_IDX);
  assign out_data  = out_valid ? mem[rd_ptr][elem_idx] : '0;
  assign full      = (row_count == DEPTH_C);

  // A full FIFO still accepts a row when the head row's final element leaves in the same cycle.
  assign beat = out_valid && out_ready;
  assign pop  = beat && (elem_idx == LAST_IDX);
  assign push = in_valid && ((row_count != DEPTH_C) || pop);

  always_comb begin
    state_d     = state;
    wr_ptr_d    = wr_ptr;
    rd_ptr_d    = rd_ptr;
    elem_idx_d  = elem_idx;
    row_count_d = row_count;
    overflow_d  = overflow;
    if (clear) begin
      state_d     = IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      elem_idx_d  = '0;
      row_count_d = '0;
      overflow_d  = 1'b0;
    end else begin
      if (beat) begin
        if (pop) begin
          elem_idx_d = '0;
          rd_ptr_d   = rd_ptr + PW'(1);
        end else begin
          elem_idx_d = elem_idx + EW'(1);
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr + PW'(1);
      end else if (in_valid) begin
        overflow_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   row_count_d = row_count + CW'(1);
        2'b01:   row_count_d = row_count - CW'(1);
        default: row_count_d = row_count;
      endcase
      state_d = (row_count_d != '0) ? SEND : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      elem_idx  <= '0;
      row_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_d;
      wr_ptr    <= wr_ptr_d;
      rd_ptr    <= rd_ptr_d;
      elem_idx  <= elem_idx_d;
      row_count <= row_count_d;
      overflow  <= overflow_d;
    end
  end

  // Row storage is never reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && push) begin
      for (int k = 0; k < MATRIX_SIZE; k++) begin
        mem[wr_ptr][k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_act_row_drain_buffer.sv
// Directed testbench for act_row_drain_buffer: row capture, drain order, stalls, overflow, clear and reset.
module tb_act_row_drain_buffer;

  localparam int DW = 16;
  localparam int MS = 8;
  localparam int RD = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic [MS*DW-1:0] in_data;
  logic            in_valid;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic [2:0]      row_count;
  logic            full;
  logic            overflow;

  int checks = 0;
  int errors = 0;

  act_row_drain_buffer #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS), .ROW_DEPTH(RD)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .row_count(row_count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [MS*DW-1:0] mk_row(input logic [15:0] base);
    logic [MS*DW-1:0] r;
    for (int k = 0; k < MS; k++) r[k*DW +: DW] = base + 16'(k);
    return r;
  endfunction

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %0b expected 0", out_last); end
    checks++; if (row_count !== 3'd0) begin errors++; $display("FAIL reset_row_count got %0d expected 0", row_count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b expected 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b expected 0", overflow); end
  endtask

  task automatic test_single_row();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = mk_row(16'h0001);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < MS; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid beat %0d got %0b expected 1", k, out_valid); end
      checks++; if (out_data !== 16'(k + 1)) begin errors++; $display("FAIL single_data beat %0d got %0h expected %0h", k, out_data, k + 1); end
      checks++; if (out_last !== (k == MS - 1)) begin errors++; $display("FAIL single_last beat %0d got %0b expected %0b", k, out_last, k == MS - 1); end
      checks++; if (row_count !== 3'd1) begin errors++; $display("FAIL single_count beat %0d got %0d expected 1", k, row_count); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %0b expected 0", out_valid); end
    checks++; if (row_count !== 3'd0) begin errors++; $display("FAIL single_idle_count got %0d expected 0", row_count); end
  endtask

  task automatic test_overflow();
    logic [15:0] bases [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1; in_data = mk_row(bases[r]);
      tick();
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %0b expected 1", full); end
    checks++; if (row_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d expected 4", row_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b expected 0", overflow); end
    in_data = mk_row(16'h5000);
    tick();
    in_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b expected 1", overflow); end
    checks++; if (row_count !== 3'd4) begin errors++; $display("FAIL ovf_count_after_drop got %0d expected 4", row_count); end
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < MS; k++) begin
        checks++; if (out_valid !== 1'b1 || out_data !== bases[r] + 16'(k)) begin
          errors++; $display("FAIL ovf_drain row %0d beat %0d got v=%0b d=%0h expected v=1 d=%0h", r, k, out_valid, out_data, bases[r] + 16'(k));
        end
        checks++; if (out_last !== (k == MS - 1)) begin errors++; $display("FAIL ovf_last row %0d beat %0d got %0b", r, k, out_last); end
        tick();
      end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty_valid got %0b expected 0", out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b expected 1", overflow); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %0b expected 0", overflow); end
  endtask

  task automatic test_full_coincident();
    logic [15:0] exp_bases [7] = '{16'h1200, 16'h1300, 16'h1400, 16'h1500, 16'h1600, 16'h1700, 16'h1800};
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1; in_data = mk_row(16'h1100 + 16'(r * 16'h0100));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < MS - 1; k++) tick();
    checks++; if (out_last !== 1'b1 || out_data !== 16'h1107) begin
      errors++; $display("FAIL coin_head_last got last=%0b d=%0h expected last=1 d=1107", out_last, out_data);
    end
    in_valid = 1'b1; in_data = mk_row(16'h1500);
    tick();
    in_valid = 1'b0;
    checks++; if (row_count !== 3'd4) begin errors++; $display("FAIL coin_count got %0d expected 4", row_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL coin_overflow got %0b expected 0", overflow); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL coin_full got %0b expected 1", full); end
    for (int r = 0; r < 7; r++) begin
      if (r == 4) begin
        out_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
          in_valid = 1'b1; in_data = mk_row(exp_bases[4 + w]);
          tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (row_count !== 3'd3) begin errors++; $display("FAIL wrap_count got %0d expected 3", row_count); end
      end
      for (int k = 0; k < MS; k++) begin
        checks++; if (out_valid !== 1'b1 || out_data !== exp_bases[r] + 16'(k)) begin
          errors++; $display("FAIL wrap_drain row %0d beat %0d got v=%0b d=%0h expected v=1 d=%0h", r, k, out_valid, out_data, exp_bases[r] + 16'(k));
        end
        tick();
      end
    end
    checks++; if (out_valid !== 1'b0 || row_count !== 3'd0) begin
      errors++; $display("FAIL wrap_empty got v=%0b cnt=%0d expected v=0 cnt=0", out_valid, row_count);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pat = 32'b1011_0010_1110_0101_1001_1101_0110_1011;
    int e = 0;
    logic [15:0] exp_d;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk_row(16'hA000);
    tick();
    in_data = mk_row(16'hB000);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 64 && e < 2 * MS; c++) begin
      out_ready = pat[c % 32];
      exp_d = (e < MS) ? 16'hA000 + 16'(e) : 16'hB000 + 16'(e - MS);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
        errors++; $display("FAIL stall_data cyc %0d got v=%0b d=%0h expected v=1 d=%0h", c, out_valid, out_data, exp_d);
      end
      checks++; if (out_last !== ((e % MS) == MS - 1)) begin errors++; $display("FAIL stall_last cyc %0d got %0b", c, out_last); end
      tick();
      if (out_ready) e++;
    end
    out_ready = 1'b1;
    checks++; if (e !== 2 * MS) begin errors++; $display("FAIL stall_beats got %0d expected %0d", e, 2 * MS); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_end_valid got %0b expected 0", out_valid); end
  endtask

  task automatic test_clear_mid_row();
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      in_valid = 1'b1; in_data = mk_row(16'hC000 + 16'(r * 16'h0100));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    checks++; if (out_data !== 16'hC003 || overflow !== 1'b1) begin
      errors++; $display("FAIL clr_pre got d=%0h ovf=%0b expected d=c003 ovf=1", out_data, overflow);
    end
    clear = 1'b1; in_valid = 1'b1; in_data = mk_row(16'h7700);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %0b expected 0", out_valid); end
    checks++; if (row_count !== 3'd0) begin errors++; $display("FAIL clr_count got %0d expected 0", row_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got %0b expected 0", overflow); end
    in_valid = 1'b1; in_data = mk_row(16'hE000);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < MS; k++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 16'hE000 + 16'(k) || out_last !== (k == MS - 1)) begin
        errors++; $display("FAIL clr_new beat %0d got v=%0b d=%0h l=%0b expected d=%0h", k, out_valid, out_data, out_last, 16'hE000 + 16'(k));
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_new_end got %0b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      in_valid = 1'b1; in_data = mk_row(16'h9000 + 16'(r * 16'h0100));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b0; in_valid = 1'b1; in_data = mk_row(16'hF000);
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++; $display("FAIL rstmid_valid got v=%0b l=%0b expected 0 0", out_valid, out_last);
    end
    checks++; if (row_count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d expected 0", row_count); end
    tick();
    checks++; if (out_valid !== 1'b0 || row_count !== 3'd0) begin
      errors++; $display("FAIL rstmid_not_stored got v=%0b cnt=%0d expected 0 0", out_valid, row_count);
    end
    in_valid = 1'b1; in_data = mk_row(16'h0A00);
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== 16'h0A00 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_restart got v=%0b d=%0h expected v=1 d=0a00", out_valid, out_data);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_row();
    test_overflow();
    test_full_coincident();
    test_stall();
    test_clear_mid_row();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
